// File: rtl/multiplier_scheduler.sv
// Round-robin scheduler that shares one multiplier among N_REQ FIFO-fed requesters.
// One transaction in flight: grant, pop operands, wait MUL_LAT, push the product.
module multiplier_scheduler #(
  parameter int N_REQ   = 4,
  parameter int DATA_W  = 16,
  parameter int PROD_W  = 32,
  parameter int MUL_LAT = 1
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [N_REQ-1:0]           req,
  input  logic [N_REQ*DATA_W-1:0]    entry_1,
  input  logic [N_REQ*DATA_W-1:0]    entry_2,
  input  logic [N_REQ-1:0]           full,
  output logic [N_REQ-1:0]           rd,
  output logic [N_REQ-1:0]           wr,
  output logic [PROD_W-1:0]          output_1,
  output logic [DATA_W-1:0]          mul_entry_1,
  output logic [DATA_W-1:0]          mul_entry_2,
  input  logic [PROD_W-1:0]          mul_output_1,
  output logic                       busy,
  output logic [$clog2(N_REQ)-1:0]   grant_id
);

  // state | meaning
  // IDLE  | waiting for an eligible requester
  // ISSUE | rd strobe high, operands on the multiplier
  // WAIT  | counting down the multiplier latency
  // WRITE | wr strobe high, product on output_1
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, WRITE} state_t;

  localparam int ID_W  = $clog2(N_REQ);
  localparam int CNT_W = (MUL_LAT > 1) ? $clog2(MUL_LAT) : 1;

  state_t             state, state_nxt;
  logic [ID_W-1:0]    rr_ptr;
  logic [ID_W-1:0]    pick;
  logic               grant_vld;
  logic [CNT_W-1:0]   lat_cnt;
  logic [N_REQ-1:0]   elig;

  // Output space is reserved at grant, so the later push can never block.
  assign elig = req & ~full;
  assign busy = (state != IDLE);

  always_comb begin
    grant_vld = 1'b0;
    pick      = '0;
    for (int k = 0; k < N_REQ; k++) begin
      int j;
      j = (int'(rr_ptr) + k) % N_REQ;
      if (!grant_vld && elig[j]) begin
        grant_vld = 1'b1;
        pick      = j[ID_W-1:0];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (grant_vld) state_nxt = ISSUE;
      ISSUE:   state_nxt = WAIT;
      WAIT:    if (lat_cnt == '0) state_nxt = WRITE;
      WRITE:   state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd          <= '0;
      wr          <= '0;
      output_1    <= '0;
      mul_entry_1 <= '0;
      mul_entry_2 <= '0;
      grant_id    <= '0;
      rr_ptr      <= '0;
      lat_cnt     <= '0;
    end else begin
      rd <= '0;
      wr <= '0;
      case (state)
        IDLE: begin
          if (grant_vld) begin
            grant_id    <= pick;
            rr_ptr      <= (int'(pick) == N_REQ-1) ? '0 : pick + 1'b1;
            mul_entry_1 <= entry_1[int'(pick)*DATA_W +: DATA_W];
            mul_entry_2 <= entry_2[int'(pick)*DATA_W +: DATA_W];
            rd[pick]    <= 1'b1;
          end
        end
        ISSUE: lat_cnt <= CNT_W'(MUL_LAT-1);
        WAIT: begin
          if (lat_cnt == '0) begin
            output_1     <= mul_output_1;
            wr[grant_id] <= 1'b1;
          end else begin
            lat_cnt <= lat_cnt - 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_multiplier_scheduler.sv
// Bench: FIFO environment plus transaction-timeline reference model for a MUL_LAT=1 instance,
// and directed latency/reset checks on a MUL_LAT=3 instance.
module tb_multiplier_scheduler;
  localparam int N  = 4;
  localparam int DW = 16;
  localparam int PW = 32;
  localparam int L1 = 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // instance with MUL_LAT=1
  logic            rst_n;
  logic [N-1:0]    req, full, rd, wr;
  logic [N*DW-1:0] e1, e2;
  logic [PW-1:0]   out1, mul_out;
  logic [DW-1:0]   m1, m2;
  logic            busy;
  logic [1:0]      gid;

  multiplier_scheduler #(.N_REQ(N), .DATA_W(DW), .PROD_W(PW), .MUL_LAT(L1)) u_dut (
    .clk(clk), .rst_n(rst_n), .req(req), .entry_1(e1), .entry_2(e2), .full(full),
    .rd(rd), .wr(wr), .output_1(out1), .mul_entry_1(m1), .mul_entry_2(m2),
    .mul_output_1(mul_out), .busy(busy), .grant_id(gid));

  always_ff @(posedge clk) mul_out <= PW'(m1) * PW'(m2);

  // instance with MUL_LAT=3
  logic            rst_n3;
  logic [N-1:0]    req3, full3, rd3, wr3;
  logic [N*DW-1:0] e1_3, e2_3;
  logic [PW-1:0]   out3, mul_out3;
  logic [DW-1:0]   m1_3, m2_3;
  logic            busy3;
  logic [1:0]      gid3;
  logic [PW-1:0]   pipe3 [3];

  multiplier_scheduler #(.N_REQ(N), .DATA_W(DW), .PROD_W(PW), .MUL_LAT(3)) u_dut3 (
    .clk(clk), .rst_n(rst_n3), .req(req3), .entry_1(e1_3), .entry_2(e2_3), .full(full3),
    .rd(rd3), .wr(wr3), .output_1(out3), .mul_entry_1(m1_3), .mul_entry_2(m2_3),
    .mul_output_1(mul_out3), .busy(busy3), .grant_id(gid3));

  always_ff @(posedge clk) begin
    pipe3[0] <= PW'(m1_3) * PW'(m2_3);
    pipe3[1] <= pipe3[0];
    pipe3[2] <= pipe3[1];
  end
  assign mul_out3 = pipe3[2];

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_cmp++;
    if (obs !== exp_v) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp_v);
    end
  endtask

  // input FIFO contents per requester
  logic [DW-1:0] fa [N][8];
  logic [DW-1:0] fb [N][8];
  int            fcnt [N];

  // reference model: phase = cycles since grant (0 = no transaction)
  int            phase = 0;
  int            g_cur = 0, g_last = 0, rr = 0;
  logic [PW-1:0] exp_prod;
  logic [DW-1:0] exp_a, exp_b;
  int            cyc = 0;

  logic          rst_next = 1'b0;
  logic [N-1:0]  full_next = '0;
  bit            rnd_mode = 1'b0;

  int            obs_rd [512];
  int            wr_cyc [512];
  int            n_rd = 0, n_wr = 0;
  int            last_rd_cyc = 0, last_wr_cyc = 0, last_wr_id = -1;
  logic [PW-1:0] last_wr_data;

  task automatic push_op(input int i, input logic [DW-1:0] a, input logic [DW-1:0] b);
    if (fcnt[i] < 8) begin
      fa[i][fcnt[i]] = a;
      fb[i][fcnt[i]] = b;
      fcnt[i]++;
    end
  endtask

  task automatic pop_op(input int i);
    for (int k = 0; k < 7; k++) begin
      fa[i][k] = fa[i][k+1];
      fb[i][k] = fb[i][k+1];
    end
    fcnt[i]--;
  endtask

  function automatic int onehot_id(input logic [N-1:0] v);
    int id;
    id = -1;
    for (int i = 0; i < N; i++) if (v[i]) id = i;
    return id;
  endfunction

  // one clock of the MUL_LAT=1 instance: check, run environment, drive, advance model
  task automatic cycle();
    logic [N-1:0] exp_rd, exp_wr, elig;
    int           g;
    @(negedge clk);
    cyc++;
    exp_rd = '0;
    exp_wr = '0;
    if (phase == 1) exp_rd[g_cur] = 1'b1;
    if (phase == L1 + 2) exp_wr[g_cur] = 1'b1;
    check_eq("rd", 32'(rd), 32'(exp_rd));
    check_eq("wr", 32'(wr), 32'(exp_wr));
    check_eq("busy", 32'(busy), 32'(phase != 0));
    check_eq("grant_id", 32'(gid), 32'(g_last));
    if (phase == 1) begin
      check_eq("mul_entry_1", 32'(m1), 32'(exp_a));
      check_eq("mul_entry_2", 32'(m2), 32'(exp_b));
    end
    if (phase == L1 + 2) check_eq("output_1", out1, exp_prod);
    if (!rst_n) check_eq("output_1_rst", out1, 32'h0);

    if (rd != '0 && n_rd < 512) begin
      obs_rd[n_rd] = onehot_id(rd);
      n_rd++;
      last_rd_cyc = cyc;
    end
    if (wr != '0) begin
      if (n_wr < 512) wr_cyc[n_wr] = cyc;
      n_wr++;
      last_wr_cyc  = cyc;
      last_wr_id   = onehot_id(wr);
      last_wr_data = out1;
    end
    for (int i = 0; i < N; i++) if (rd[i] && fcnt[i] > 0) pop_op(i);

    if (rnd_mode) begin
      for (int i = 0; i < N; i++)
        if ($urandom_range(0, 2) == 0) push_op(i, DW'($urandom), DW'($urandom));
      full_next = N'($urandom_range(0, 15)) & N'($urandom_range(0, 15));
    end
    rst_n = rst_next;
    full  = full_next;
    for (int i = 0; i < N; i++) begin
      req[i] = (fcnt[i] != 0);
      e1[i*DW +: DW] = fa[i][0];
      e2[i*DW +: DW] = fb[i][0];
    end

    if (!rst_n) begin
      phase = 0; g_last = 0; rr = 0;
    end else if (phase == 0) begin
      elig = req & ~full;
      g = -1;
      for (int k = 0; k < N; k++)
        if (g < 0 && elig[(rr + k) % N]) g = (rr + k) % N;
      if (g >= 0) begin
        g_cur = g; g_last = g; rr = (g + 1) % N;
        exp_a = fa[g][0]; exp_b = fb[g][0];
        exp_prod = PW'(fa[g][0]) * PW'(fb[g][0]);
        phase = 1;
      end
    end else if (phase == L1 + 2) begin
      phase = 0;
    end else begin
      phase++;
    end
  endtask

  int            k_wr, n_wr3;
  logic [PW-1:0] d3;

  // issue one request on the MUL_LAT=3 instance and watch up to 9 cycles for its push
  task automatic run3(input string tag, input int rid, input logic [DW-1:0] a, input logic [DW-1:0] b,
                      input logic [PW-1:0] prod);
    @(negedge clk);
    req3 = '0; req3[rid] = 1'b1;
    e1_3[rid*DW +: DW] = a;
    e2_3[rid*DW +: DW] = b;
    @(negedge clk);
    req3 = '0;
    check_eq({tag, "_rd"}, 32'(rd3), 32'(1 << rid));
    check_eq({tag, "_gid"}, 32'(gid3), 32'(rid));
    k_wr = -1; n_wr3 = 0;
    for (int k = 2; k <= 9; k++) begin
      @(negedge clk);
      if (wr3 != '0) begin
        n_wr3++;
        if (k_wr < 0) begin
          k_wr = k; d3 = out3;
          check_eq({tag, "_wr_id"}, 32'(wr3), 32'(1 << rid));
        end
      end
    end
    check_eq({tag, "_latency"}, 32'(k_wr), 32'd5);
    check_eq({tag, "_wr_count"}, 32'(n_wr3), 32'd1);
    check_eq({tag, "_product"}, d3, prod);
  endtask

  initial begin
    for (int i = 0; i < N; i++) begin
      fcnt[i] = 0;
      for (int k = 0; k < 8; k++) begin fa[i][k] = '0; fb[i][k] = '0; end
    end
    rst_n = 1'b0; req = '0; full = '0; e1 = '0; e2 = '0;
    rst_n3 = 1'b0; req3 = '0; full3 = '0; e1_3 = '0; e2_3 = '0;

    // reset with every requester pending, then grant order 0,1,2,3,0
    push_op(0, 16'h0003, 16'h0004);
    push_op(0, 16'h0100, 16'h0100);
    push_op(1, 16'h0005, 16'h0006);
    push_op(2, 16'hFFFF, 16'hFFFF);
    push_op(3, 16'h8000, 16'h0002);
    rst_next = 1'b0;
    for (int c = 0; c < 4; c++) cycle();
    rst_next = 1'b1;
    rst_n3   = 1'b1;
    n_rd = 0; n_wr = 0;
    for (int c = 0; c < 24; c++) cycle();
    check_eq("rr_count", 32'(n_rd), 32'd5);
    for (int k = 0; k < 5; k++) check_eq("rr_order", 32'(obs_rd[k]), 32'(k % N));
    for (int k = 0; k < 4; k++) check_eq("wr_spacing", 32'(wr_cyc[k+1] - wr_cyc[k]), 32'd4);

    // single request, MUL_LAT=1 timing and product
    push_op(0, 16'h0065, 16'h0047);
    for (int c = 0; c < 8; c++) cycle();
    check_eq("t2_id", 32'(last_wr_id), 32'd0);
    check_eq("t2_prod", last_wr_data, 32'h00001C03);
    check_eq("t2_rd_to_wr", 32'(last_wr_cyc - last_rd_cyc), 32'd2);

    // full requester is skipped, then served once space frees
    full_next = 4'b0010;
    push_op(1, 16'h0011, 16'h0022);
    push_op(2, 16'h00C7, 16'h0053);
    for (int c = 0; c < 8; c++) cycle();
    check_eq("t4_id", 32'(last_wr_id), 32'd2);
    check_eq("t4_prod", last_wr_data, 32'h00004085);
    check_eq("t4_skipped_kept", 32'(fcnt[1]), 32'd1);
    full_next = '0;
    for (int c = 0; c < 8; c++) cycle();
    check_eq("t4_late_id", 32'(last_wr_id), 32'd1);
    check_eq("t4_late_prod", last_wr_data, 32'h00000242);

    // randomized traffic with random back-pressure
    rnd_mode = 1'b1;
    for (int c = 0; c < 400; c++) cycle();
    rnd_mode = 1'b0;
    full_next = '0;
    for (int c = 0; c < 40; c++) cycle();

    // MUL_LAT=3 latency and product
    run3("t5", 0, 16'h0C84, 16'h0965, 32'h00759414);

    // reset during WAIT discards the transaction
    @(negedge clk);
    req3 = 4'b0100;
    e1_3[2*DW +: DW] = 16'h1234;
    e2_3[2*DW +: DW] = 16'h0002;
    @(negedge clk);
    req3 = '0;
    @(negedge clk);
    rst_n3 = 1'b0;
    #1;
    check_eq("t6_rd", 32'(rd3), 32'h0);
    check_eq("t6_wr", 32'(wr3), 32'h0);
    check_eq("t6_out", out3, 32'h0);
    check_eq("t6_busy", 32'(busy3), 32'h0);
    check_eq("t6_gid", 32'(gid3), 32'h0);
    check_eq("t6_mul_a", 32'(m1_3), 32'h0);
    n_wr3 = 0;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      if (wr3 != '0) n_wr3++;
    end
    rst_n3 = 1'b1;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (wr3 != '0) n_wr3++;
    end
    check_eq("t6_no_wr", 32'(n_wr3), 32'h0);
    check_eq("t6_idle", 32'(busy3), 32'h0);
    run3("t6_after", 2, 16'h0003, 16'h0005, 32'h0000000F);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
